// File: rtl/masked_q12_layer_if.sv
// Share bus of the masked Q12 S-box layer: enable, input shares and output shares.
// Latency: none (wiring only); the slave side sets the pipeline depth.
// Backpressure: none; en stalls the whole pipeline. Lane n is bits [4n+3:4n] = {d,c,b,a}.
interface masked_q12_layer_if #(
    parameter int NB = 16
);
    logic            en;         // pipeline advance, 0 = hold every register
    logic            in_valid;   // input shares valid
    logic [4*NB-1:0] in1;        // input share 1
    logic [4*NB-1:0] in2;        // input share 2
    logic [4*NB-1:0] in3;        // input share 3
    logic            out_valid;  // output shares valid
    logic [4*NB-1:0] out1;       // output share 1
    logic [4*NB-1:0] out2;       // output share 2
    logic [4*NB-1:0] out3;       // output share 3

    modport master (
        output en, in_valid, in1, in2, in3,
        input  out_valid, out1, out2, out3
    );

    modport slave (
        input  en, in_valid, in1, in2, in3,
        output out_valid, out1, out2, out3
    );
endinterface

// File: rtl/masked_q12_layer.sv
// Three-share, randomness-free masked layer of NB Q12 S-boxes (y = {d, c^db, b^d(b^c), a}).
// Latency: 1 + OUT_REG enabled cycles, one result per enabled cycle.
// Backpressure: none; en=0 freezes every register, so in_valid is ignored and out_valid holds.
// Ports: clk, rst_n (async active-low), bus (slave modport: en, in_valid, in1..3 -> out_valid, out1..3).
module masked_q12_layer #(
    parameter int NB      = 16,
    parameter int OUT_REG = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    masked_q12_layer_if.slave    bus
);

    // Which output share owns the product d_k * b_i (and d_k * c_i).  Both
    // ownership maps are upper triangular in the share index with the same
    // diagonal, so for any fixed sharing of d the map (b,c) -> (y1,y2) on
    // shares is unitriangular and hence a bijection: the output sharing is
    // uniform without fresh randomness.
    function automatic int owner_b(input int i, input int k);
        case (i)
            0:       return 0;
            1:       return (k == 1) ? 1 : 0;
            default: return (k == 2) ? 2 : ((k == 0) ? 1 : 0);
        endcase
    endfunction

    function automatic int owner_c(input int i, input int k);
        case (i)
            0:       return 0;
            1:       return (k == 1) ? 1 : 0;
            default: return (k == 2) ? 2 : ((k == 1) ? 1 : 0);
        endcase
    endfunction

    logic [2:0][4*NB-1:0]   sh_in;
    logic [2:0][4*NB-1:0]   sh_s1;

    // Component slot p = 3*i + k of output share K sees only b_i, c_i and d_k.
    logic [NB-1:0][2:0][8:0] y1_comp_d, y1_comp_q;
    logic [NB-1:0][2:0][8:0] y2_comp_d, y2_comp_q;
    logic [NB-1:0][2:0]      a_d, a_q;
    logic [NB-1:0][2:0]      d_d, d_q;
    logic                    vld1_d, vld1_q;

    assign sh_in[0] = bus.in1;
    assign sh_in[1] = bus.in2;
    assign sh_in[2] = bus.in3;

    always_comb begin
        y1_comp_d = y1_comp_q;
        y2_comp_d = y2_comp_q;
        a_d       = a_q;
        d_d       = d_q;
        vld1_d    = vld1_q;
        if (bus.en) begin
            vld1_d = bus.in_valid;
            // Data registers load only on valid input, so after reset the
            // outputs stay zero until a real token arrives.
            if (bus.in_valid) begin
                for (int n = 0; n < NB; n++) begin
                    for (int s = 0; s < 3; s++) begin
                        a_d[n][s] = sh_in[s][4*n];
                        d_d[n][s] = sh_in[s][4*n+3];
                    end
                    for (int kk = 0; kk < 3; kk++) begin
                        for (int i = 0; i < 3; i++) begin
                            for (int k = 0; k < 3; k++) begin
                                y1_comp_d[n][kk][3*i+k] =
                                      ((owner_b(i, k) == kk) ? (sh_in[k][4*n+3] & sh_in[i][4*n+1]) : 1'b0)
                                    ^ ((owner_c(i, k) == kk) ? (sh_in[k][4*n+3] & sh_in[i][4*n+2]) : 1'b0)
                                    ^ ((i == kk && k == kk)  ? sh_in[i][4*n+1] : 1'b0);
                                y2_comp_d[n][kk][3*i+k] =
                                      ((owner_b(i, k) == kk) ? (sh_in[k][4*n+3] & sh_in[i][4*n+1]) : 1'b0)
                                    ^ ((i == kk && k == kk)  ? sh_in[i][4*n+2] : 1'b0);
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y1_comp_q <= '0;
            y2_comp_q <= '0;
            a_q       <= '0;
            d_q       <= '0;
            vld1_q    <= 1'b0;
        end else begin
            y1_comp_q <= y1_comp_d;
            y2_comp_q <= y2_comp_d;
            a_q       <= a_d;
            d_q       <= d_d;
            vld1_q    <= vld1_d;
        end
    end

    // Compression after the registers: three 3-input XORs feeding a fourth.
    always_comb begin
        sh_s1 = '0;
        for (int n = 0; n < NB; n++) begin
            for (int kk = 0; kk < 3; kk++) begin
                sh_s1[kk][4*n]   = a_q[n][kk];
                sh_s1[kk][4*n+1] = (^y1_comp_q[n][kk][2:0]) ^ (^y1_comp_q[n][kk][5:3]) ^ (^y1_comp_q[n][kk][8:6]);
                sh_s1[kk][4*n+2] = (^y2_comp_q[n][kk][2:0]) ^ (^y2_comp_q[n][kk][5:3]) ^ (^y2_comp_q[n][kk][8:6]);
                sh_s1[kk][4*n+3] = d_q[n][kk];
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [2:0][4*NB-1:0] out_d, out_q;
        logic                 vld2_d, vld2_q;

        always_comb begin
            out_d  = out_q;
            vld2_d = vld2_q;
            if (bus.en) begin
                vld2_d = vld1_q;
                if (vld1_q) begin
                    out_d = sh_s1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q  <= '0;
                vld2_q <= 1'b0;
            end else begin
                out_q  <= out_d;
                vld2_q <= vld2_d;
            end
        end

        assign bus.out_valid = vld2_q;
        assign bus.out1      = out_q[0];
        assign bus.out2      = out_q[1];
        assign bus.out3      = out_q[2];
    end else begin : g_no_out_reg
        assign bus.out_valid = vld1_q;
        assign bus.out1      = sh_s1[0];
        assign bus.out2      = sh_s1[1];
        assign bus.out3      = sh_s1[2];
    end

endmodule

// File: tb/tb_masked_q12_layer.sv
// Self-checking bench: NB=16/OUT_REG=1 and NB=1/OUT_REG=0 instances against a queue model.
// Latency: model delays unmasked Q values by 2 resp. 1 enabled cycles.
// Backpressure: en is randomised; the model only advances on enabled edges.
module tb_masked_q12_layer;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    bit   chk_en = 1'b0;
    int   n_vec  = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    masked_q12_layer_if #(.NB(16)) ia ();
    masked_q12_layer_if #(.NB(1))  ib ();

    masked_q12_layer #(.NB(16), .OUT_REG(1)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    masked_q12_layer #(.NB(1),  .OUT_REG(0)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    // ---------------- reference model ----------------
    function automatic logic [3:0] q4(input logic [3:0] x);
        logic a, b, c, d;
        {d, c, b, a} = x;
        return {d, c ^ (d & b), b ^ (d & (b ^ c)), a};
    endfunction

    function automatic logic [63:0] qmap(input logic [63:0] x);
        logic [63:0] y;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = q4(x[4*n +: 4]);
        return y;
    endfunction

    typedef struct {
        bit          v;
        logic [63:0] y;
    } tok_t;

    tok_t qa[$];
    tok_t qb[$];
    bit   za, zb;   // no valid output yet since reset: shares must read zero

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            repeat (2) qa.push_back('{1'b0, 64'h0});
            qb.push_back('{1'b0, 64'h0});
            za = 1'b1;
            zb = 1'b1;
        end else begin
            if (ia.en) begin
                qa.push_back('{ia.in_valid, qmap(ia.in1 ^ ia.in2 ^ ia.in3)});
                void'(qa.pop_front());
            end
            if (ib.en) begin
                qb.push_back('{ib.in_valid, {60'h0, q4(ib.in1 ^ ib.in2 ^ ib.in3)}});
                void'(qb.pop_front());
            end
            if (qa[0].v) za = 1'b0;
            if (qb[0].v) zb = 1'b0;
        end
    end

    always @(posedge clk) if (chk_en && rst_n) n_vec++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            if (!rst_n) begin
                chk("a_rst_vld", 64'(ia.out_valid), 64'h0);
                chk("a_rst_dat", 64'(|{ia.out1, ia.out2, ia.out3}), 64'h0);
                chk("b_rst_vld", 64'(ib.out_valid), 64'h0);
                chk("b_rst_dat", 64'(|{ib.out1, ib.out2, ib.out3}), 64'h0);
            end else begin
                chk("a_vld", 64'(ia.out_valid), 64'(qa[0].v));
                if (qa[0].v) chk("a_dat", ia.out1 ^ ia.out2 ^ ia.out3, qa[0].y);
                else if (za) chk("a_zero", 64'(|{ia.out1, ia.out2, ia.out3}), 64'h0);
                chk("b_vld", 64'(ib.out_valid), 64'(qb[0].v));
                if (qb[0].v) chk("b_dat", 64'(ib.out1 ^ ib.out2 ^ ib.out3), qb[0].y);
                else if (zb) chk("b_zero", 64'(|{ib.out1, ib.out2, ib.out3}), 64'h0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_a(input bit v, input logic [63:0] x);
        logic [63:0] s1, s2;
        s1 = {$urandom, $urandom};
        s2 = {$urandom, $urandom};
        ia.in_valid = v;
        ia.in1 = s1;
        ia.in2 = s2;
        ia.in3 = x ^ s1 ^ s2;
    endtask

    task automatic drive_b(input bit v, input logic [3:0] x);
        logic [3:0] s1, s2;
        s1 = 4'($urandom);
        s2 = 4'($urandom);
        ib.in_valid = v;
        ib.in1 = s1;
        ib.in2 = s2;
        ib.in3 = x ^ s1 ^ s2;
    endtask

    int hist [4096];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] tok;
        logic [11:0] idx;
        int          cnt;

        ia.en = 1'b1; ib.en = 1'b1;
        drive_a(1'b0, 64'h0);
        drive_b(1'b0, 4'h0);
        for (int i = 0; i < 4096; i++) hist[i] = 0;

        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Model pins against hand-derived values from the Q table 0123456789CDEFAB.
        chk("pin_qA", qmap(64'hA), 64'hC);
        chk("pin_q_ramp", qmap(64'hFEDCBA9876543210), 64'hBAFEDC9876543210);

        // Single literal token through the 1-lane, latency-1 instance.
        @(posedge clk); #1;
        ib.in1 = 4'hA; ib.in2 = 4'h0; ib.in3 = 4'h0; ib.in_valid = 1'b1;
        @(posedge clk); #1;
        drive_b(1'b0, 4'h0);
        @(negedge clk);
        chk("lit_b_vld", 64'(ib.out_valid), 64'h1);
        chk("lit_b_dat", 64'(ib.out1 ^ ib.out2 ^ ib.out3), 64'hC);

        // Back-to-back stream of the ramp constant, latency 2, no gaps.
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            drive_a(c < 8, 64'hFEDCBA9876543210);
            @(negedge clk);
            if (c >= 2) begin
                chk("ramp_vld", 64'(ia.out_valid), 64'h1);
                chk("ramp_dat", ia.out1 ^ ia.out2 ^ ia.out3, 64'hBAFEDC9876543210);
            end
        end

        // Stall with a token in flight.
        repeat (3) begin @(posedge clk); #1; drive_a(1'b0, 64'h0); end
        tok = {$urandom, $urandom};
        @(posedge clk); #1; drive_a(1'b1, tok);
        @(posedge clk); #1; ia.en = 1'b0; drive_a(1'b1, {$urandom, $urandom});
        repeat (3) @(posedge clk);
        #1 ia.en = 1'b1; drive_a(1'b0, 64'h0);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!ia.out_valid && cnt < 6);
        chk("stall_wait", 64'(cnt), 64'd2);
        chk("stall_dat", ia.out1 ^ ia.out2 ^ ia.out3, qmap(tok));

        // Asynchronous reset mid-stream.
        repeat (4) begin
            @(posedge clk); #1;
            drive_a(1'b1, {$urandom, $urandom});
            drive_b(1'b1, 4'($urandom));
        end
        @(negedge clk);
        chk("pre_rst_vld", 64'({ia.out_valid, ib.out_valid}), 64'h3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld", 64'({ia.out_valid, ib.out_valid}), 64'h0);
        chk("arst_dat", 64'(|{ia.out1, ia.out2, ia.out3, ib.out1, ib.out2, ib.out3}), 64'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            drive_a(1'b0, {$urandom, $urandom});
            drive_b(1'b0, 4'($urandom));
        end

        // Randomised traffic with random stalls on both instances.
        repeat (400) begin
            @(posedge clk); #1;
            ia.en = ($urandom_range(0, 7) != 0);
            ib.en = ($urandom_range(0, 7) != 0);
            drive_a($urandom_range(0, 9) < 7, {$urandom, $urandom});
            drive_b($urandom_range(0, 9) < 7, 4'($urandom));
        end

        // Exhaustive sweep of all 4096 share triples on the 1-lane instance.
        for (int t = 0; t <= 4096; t++) begin
            @(posedge clk); #1;
            ib.en = 1'b1;
            ia.en = 1'b1;
            drive_a(1'b0, 64'h0);
            if (t < 4096) begin
                idx = 12'(t);
                ib.in1 = idx[3:0];
                ib.in2 = idx[7:4];
                ib.in3 = idx[11:8];
                ib.in_valid = 1'b1;
            end else begin
                drive_b(1'b0, 4'h0);
            end
            @(negedge clk);
            if (t >= 1) hist[{ib.out1, ib.out2, ib.out3}]++;
        end
        for (int y = 0; y < 16; y++) begin
            cnt = 0;
            for (int i = 0; i < 4096; i++) begin
                idx = 12'(i);
                if ((idx[11:8] ^ idx[7:4] ^ idx[3:0]) == 4'(y) && hist[i] == 1) cnt++;
            end
            chk($sformatf("uniform_y%0d", y), 64'(cnt), 64'd256);
        end

        repeat (3) @(posedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
